// File: rtl/e203_extend_csr_bank.sv
// NICE extended-CSR bank: scratch registers, a free-running cycle counter and a
// status register behind a valid/ready request channel with a delayed response.
module e203_extend_csr_bank #(
   parameter int unsigned CSR_NUM  = 4,
   parameter logic [31:0] CSR_BASE = 32'hBC0,
   parameter int unsigned RSP_LAT  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        nice_csr_valid,
   output logic        nice_csr_ready,
   input  logic [31:0] nice_csr_addr,
   input  logic        nice_csr_wr,
   input  logic [31:0] nice_csr_wdata,
   output logic        nice_csr_rsp_valid,
   input  logic        nice_csr_rsp_ready,
   output logic [31:0] nice_csr_rdata,
   output logic        nice_csr_rsp_err
);

   localparam int unsigned SCR_NUM  = CSR_NUM - 2;
   localparam int unsigned CYC_IDX  = CSR_NUM - 2;
   localparam int unsigned STS_IDX  = CSR_NUM - 1;
   localparam logic [3:0]  CNT_INIT = (RSP_LAT == 0) ? 4'd0 : 4'(RSP_LAT - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] scratch_q [SCR_NUM];
   logic [31:0] cycle_q;
   logic        sts_err_q;
   logic [7:0]  sts_wcnt_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        accept;
   logic [31:0] idx;
   logic        in_range;
   logic        hit_cycle;
   logic        hit_status;
   logic        acc_err;
   logic        wr_ok;
   logic [31:0] rd_val;

   assign accept     = nice_csr_valid & nice_csr_ready;
   assign idx        = nice_csr_addr - CSR_BASE;
   assign in_range   = (nice_csr_addr >= CSR_BASE) && (idx < 32'(CSR_NUM));
   assign hit_cycle  = in_range && (idx == 32'(CYC_IDX));
   assign hit_status = in_range && (idx == 32'(STS_IDX));
   assign acc_err    = !in_range || (nice_csr_wr && hit_cycle);
   assign wr_ok      = nice_csr_wr && !acc_err;

   // Register value as seen before the accept edge updates anything.
   always_comb begin
      rd_val = '0;
      for (int i = 0; i < SCR_NUM; i++) begin
         if (in_range && idx == 32'(i)) rd_val = scratch_q[i];
      end
      if (hit_cycle)  rd_val = cycle_q;
      if (hit_status) rd_val = {16'h0, sts_wcnt_q, 7'h0, sts_err_q};
   end

   // NOTE: the scratch array is a handful of flops, not a RAM, so it is reset along with everything else.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SCR_NUM; i++) scratch_q[i] <= '0;
      end else if (accept && wr_ok) begin
         for (int i = 0; i < SCR_NUM; i++) begin
            if (idx == 32'(i)) scratch_q[i] <= nice_csr_wdata;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cycle_q <= '0;
      else     cycle_q <= cycle_q + 32'd1;
   end

   // A new error outranks a simultaneous W1C clear of the sticky flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sts_err_q  <= 1'b0;
         sts_wcnt_q <= '0;
      end else if (accept) begin
         if (acc_err) sts_err_q <= 1'b1;
         else if (wr_ok && hit_status && nice_csr_wdata[0]) sts_err_q <= 1'b0;
         if (wr_ok && sts_wcnt_q != 8'hFF) sts_wcnt_q <= sts_wcnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (accept) begin
         err_q   <= acc_err;
         rdata_q <= (nice_csr_wr || acc_err) ? 32'h0 : rd_val;
      end
   end

   // NOTE: the state register uses non-blocking assignment; the next-state logic below is purely combinational.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: defaults first so every path assigns state_d and cnt_d and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               cnt_d   = CNT_INIT;
               state_d = (RSP_LAT == 0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         RESP: begin
            if (nice_csr_rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign nice_csr_ready     = (state_q == IDLE);
   assign nice_csr_rsp_valid = (state_q == RESP);
   assign nice_csr_rdata     = rdata_q;
   assign nice_csr_rsp_err   = err_q;

endmodule

// File: tb/tb_e203_extend_csr_bank.sv
// Self-checking bench for e203_extend_csr_bank: scoreboard of expected responses
// filled at request acceptance, compared when each response appears.
module tb_e203_extend_csr_bank;

   localparam int unsigned CSR_NUM = 4;
   localparam logic [31:0] BASE    = 32'hBC0;
   localparam int unsigned LAT     = 1;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0, valid_lat = 1'b0, wr = 1'b0;
   logic        rsp_ready = 1'b0, rsp_ready_lat = 1'b0;
   logic [31:0] addr = '0, wdata = '0;

   logic        ready, rsp_valid, rsp_err;
   logic [31:0] rdata;
   logic        ready0, rsp_valid0, rsp_err0;
   logic [31:0] rdata0;
   logic        ready15, rsp_valid15, rsp_err15;
   logic [31:0] rdata15;

   int checks = 0;
   int errors = 0;

   rsp_t        sb[$];
   rsp_t        last_exp;
   logic [31:0] scratch_m [CSR_NUM-2];
   logic        flag_m;
   logic [7:0]  wcnt_m;
   logic [31:0] tick;
   logic [31:0] cyc_off = '0;

   e203_extend_csr_bank #(.CSR_NUM(CSR_NUM), .CSR_BASE(BASE), .RSP_LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .nice_csr_valid(valid), .nice_csr_ready(ready),
      .nice_csr_addr(addr), .nice_csr_wr(wr), .nice_csr_wdata(wdata),
      .nice_csr_rsp_valid(rsp_valid), .nice_csr_rsp_ready(rsp_ready),
      .nice_csr_rdata(rdata), .nice_csr_rsp_err(rsp_err)
   );

   e203_extend_csr_bank #(.CSR_NUM(CSR_NUM), .CSR_BASE(BASE), .RSP_LAT(0)) dut_lat0 (
      .clk(clk), .rst(rst),
      .nice_csr_valid(valid_lat), .nice_csr_ready(ready0),
      .nice_csr_addr(addr), .nice_csr_wr(wr), .nice_csr_wdata(wdata),
      .nice_csr_rsp_valid(rsp_valid0), .nice_csr_rsp_ready(rsp_ready_lat),
      .nice_csr_rdata(rdata0), .nice_csr_rsp_err(rsp_err0)
   );

   e203_extend_csr_bank #(.CSR_NUM(CSR_NUM), .CSR_BASE(BASE), .RSP_LAT(15)) dut_lat15 (
      .clk(clk), .rst(rst),
      .nice_csr_valid(valid_lat), .nice_csr_ready(ready15),
      .nice_csr_addr(addr), .nice_csr_wr(wr), .nice_csr_wdata(wdata),
      .nice_csr_rsp_valid(rsp_valid15), .nice_csr_rsp_ready(rsp_ready_lat),
      .nice_csr_rdata(rdata15), .nice_csr_rsp_err(rsp_err15)
   );

   always #5 clk = ~clk;

   // Cycles elapsed since reset; the counter register must track this (plus any preload offset).
   always @(posedge clk or posedge rst) begin
      if (rst) tick <= '0;
      else     tick <= tick + 32'd1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      for (int i = 0; i < CSR_NUM - 2; i++) scratch_m[i] = '0;
      flag_m  = 1'b0;
      wcnt_m  = '0;
      cyc_off = '0;
      sb.delete();
   endtask

   function automatic rsp_t model_access(input logic [31:0] a, input logic w, input logic [31:0] d);
      rsp_t        r;
      logic [31:0] idx;
      logic        in_r, e;
      idx     = a - BASE;
      in_r    = (a >= BASE) && (idx < CSR_NUM);
      e       = !in_r || (w && idx == CSR_NUM - 2);
      r.err   = e;
      r.rdata = '0;
      if (!e && !w) begin
         if (idx < CSR_NUM - 2)       r.rdata = scratch_m[int'(idx)];
         else if (idx == CSR_NUM - 2) r.rdata = tick + cyc_off;
         else                         r.rdata = {16'h0, wcnt_m, 7'h0, flag_m};
      end
      if (!e && w) begin
         if (idx < CSR_NUM - 2) scratch_m[int'(idx)] = d;
         if (idx == CSR_NUM - 1 && d[0]) flag_m = 1'b0;
         if (wcnt_m != 8'hFF) wcnt_m = wcnt_m + 8'd1;
      end
      if (e) flag_m = 1'b1;
      return r;
   endfunction

   // Starts and ends just after a falling edge; returns one falling edge after the accept edge.
   task automatic send(input logic [31:0] a, input logic w, input logic [31:0] d);
      int n = 0;
      valid = 1'b1; addr = a; wr = w; wdata = d;
      while (ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (ready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL send_ready addr=%h: ready=%b, required 1", a, ready);
         valid = 1'b0;
         return;
      end
      sb.push_back(model_access(a, w, d));
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic wait_rsp(input int exp_lat, input string name);
      int   lat = 1;
      rsp_t e;
      while (rsp_valid !== 1'b1 && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      checks++;
      if (rsp_valid !== 1'b1 || lat != exp_lat) begin
         errors++;
         $display("FAIL %s latency: got %0d cycles (rsp_valid=%b), required %0d", name, lat, rsp_valid, exp_lat);
      end
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard: response with no expected entry", name);
         return;
      end
      e = sb.pop_front();
      last_exp = e;
      if (rdata !== e.rdata || rsp_err !== e.err) begin
         errors++;
         $display("FAIL %s data: rdata=%h err=%b, required rdata=%h err=%b", name, rdata, rsp_err, e.rdata, e.err);
      end
   endtask

   task automatic release_rsp(input string name);
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++;
      if (ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s return_idle: ready=%b rsp_valid=%b, required 1/0", name, ready, rsp_valid);
      end
   endtask

   task automatic transact(input logic [31:0] a, input logic w, input logic [31:0] d, input string name);
      send(a, w, d);
      wait_rsp(LAT + 1, name);
      release_rsp(name);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (ready !== 1'b1 || rsp_valid !== 1'b0 || rdata !== 32'h0 || rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: ready=%b rsp_valid=%b rdata=%h err=%b, required 1/0/0/0",
                  ready, rsp_valid, rdata, rsp_err);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write_read();
      transact(BASE,        1'b1, 32'hDEADBEEF, "wr_scratch0");
      transact(BASE,        1'b0, 32'h0,        "rd_scratch0");
      transact(BASE + 1,    1'b1, 32'h12345678, "wr_scratch1");
      transact(BASE + 1,    1'b0, 32'h0,        "rd_scratch1");
      transact(BASE + 2,    1'b0, 32'h0,        "rd_cycle");
      transact(BASE + 3,    1'b0, 32'h0,        "rd_status");
   endtask

   task automatic test_back_pressure();
      send(BASE + 1, 1'b0, 32'h0);
      wait_rsp(LAT + 1, "bp_read");
      for (int i = 0; i < 5; i++) begin
         valid = 1'b1; wr = 1'b1; addr = BASE; wdata = 32'hBAD0BAD0;
         checks++;
         if (rsp_valid !== 1'b1 || rdata !== last_exp.rdata || rsp_err !== last_exp.err || ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold cycle %0d: rsp_valid=%b rdata=%h err=%b ready=%b, required 1/%h/%b/0",
                     i, rsp_valid, rdata, rsp_err, ready, last_exp.rdata, last_exp.err);
         end
         @(posedge clk);
         @(negedge clk);
      end
      valid = 1'b0;
      release_rsp("bp_release");
      transact(BASE, 1'b0, 32'h0, "bp_no_accept");
   endtask

   task automatic test_errors();
      transact(BASE + 4, 1'b0, 32'h0,        "rd_out_of_range_hi");
      transact(BASE - 1, 1'b0, 32'h0,        "rd_out_of_range_lo");
      transact(BASE + 3, 1'b0, 32'h0,        "rd_status_flag_set");
      transact(BASE + 3, 1'b1, 32'h1,        "w1c_status");
      transact(BASE + 3, 1'b0, 32'h0,        "rd_status_flag_clr");
      transact(BASE + 2, 1'b1, 32'h55555555, "wr_cycle_err");
      transact(BASE + 2, 1'b0, 32'h0,        "rd_cycle_after_wr");
      transact(BASE + 4, 1'b1, 32'hFFFFFFFF, "wr_out_of_range");
      transact(BASE,     1'b0, 32'h0,        "rd_scratch0_after_oor");
      transact(BASE + 3, 1'b0, 32'h0,        "rd_status_after_errs");
   endtask

   task automatic test_cycle_wrap();
      force dut.cycle_q = 32'hFFFF_FFFE;
      #1;
      release dut.cycle_q;
      cyc_off = 32'hFFFF_FFFE - tick;
      transact(BASE + 2, 1'b0, 32'h0, "rd_cycle_prewrap");
      transact(BASE + 2, 1'b0, 32'h0, "rd_cycle_postwrap");
   endtask

   task automatic test_write_saturation();
      int n = 0;
      while (wcnt_m != 8'hFE && n < 300) begin
         transact(BASE, 1'b1, 32'(n), "sat_fill");
         n++;
      end
      transact(BASE + 3, 1'b0, 32'h0, "rd_status_cnt_fe");
      for (int i = 0; i < 4; i++) transact(BASE + 1, 1'b1, 32'hA000 + 32'(i), "sat_over");
      transact(BASE + 3, 1'b0, 32'h0, "rd_status_cnt_ff");
      transact(BASE + 1, 1'b0, 32'h0, "rd_scratch1_after_sat");
   endtask

   task automatic test_reset_mid_wait();
      send(BASE, 1'b0, 32'h0);
      rst = 1'b1;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_wait: rsp_valid=%b ready=%b, required 0/1", rsp_valid, ready);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_dropped_rsp: rsp_valid=%b, required 0", rsp_valid);
         end
      end
      transact(BASE,     1'b0, 32'h0, "rd_scratch0_after_rst");
      transact(BASE + 2, 1'b0, 32'h0, "rd_cycle_after_rst");
      transact(BASE + 3, 1'b0, 32'h0, "rd_status_after_rst");
   endtask

   task automatic test_latency_builds();
      int n = 1;
      int lat0 = 0;
      int lat15 = 0;
      checks++;
      if (ready0 !== 1'b1 || ready15 !== 1'b1) begin
         errors++;
         $display("FAIL lat_idle: ready0=%b ready15=%b, required 1/1", ready0, ready15);
      end
      valid_lat = 1'b1; wr = 1'b1; addr = BASE; wdata = 32'h0000_0001;
      @(posedge clk);
      @(negedge clk);
      valid_lat = 1'b0;
      while ((lat0 == 0 || lat15 == 0) && n < 40) begin
         if (lat0 == 0 && rsp_valid0 === 1'b1) lat0 = n;
         if (lat15 == 0 && rsp_valid15 === 1'b1) lat15 = n;
         if (lat0 == 0 || lat15 == 0) begin
            @(posedge clk);
            n++;
            @(negedge clk);
         end
      end
      checks++;
      if (lat0 != 1) begin
         errors++;
         $display("FAIL lat0_latency: got %0d cycles, required 1", lat0);
      end
      checks++;
      if (lat15 != 16) begin
         errors++;
         $display("FAIL lat15_latency: got %0d cycles, required 16", lat15);
      end
      checks++;
      if (rsp_err0 !== 1'b0 || rsp_err15 !== 1'b0 || rdata0 !== 32'h0 || rdata15 !== 32'h0) begin
         errors++;
         $display("FAIL lat_rsp_data: err0=%b err15=%b rdata0=%h rdata15=%h, required 0/0/0/0",
                  rsp_err0, rsp_err15, rdata0, rdata15);
      end
      rsp_ready_lat = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready_lat = 1'b0;
      checks++;
      if (ready0 !== 1'b1 || ready15 !== 1'b1 || rsp_valid0 !== 1'b0 || rsp_valid15 !== 1'b0) begin
         errors++;
         $display("FAIL lat_return_idle: ready0=%b ready15=%b v0=%b v15=%b, required 1/1/0/0",
                  ready0, ready15, rsp_valid0, rsp_valid15);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_back_pressure();
      test_errors();
      test_cycle_wrap();
      test_write_saturation();
      test_reset_mid_wait();
      test_latency_builds();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
